// File: rtl/apb4_master.sv
// APB4 requester: turns a valid/ready command/response handshake into APB4 SETUP/ACCESS transfers.
// Optional ACCESS watchdog enabled by defining APB4_MASTER_TIMEOUT_EN.
module apb4_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    if ((DATA_WIDTH != 8) && (DATA_WIDTH != 16) && (DATA_WIDTH != 32)) begin : g_bad_width
        $error("apb4_master: DATA_WIDTH must be 8, 16 or 32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb4_master: TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0] state;
    logic       accept;

    assign cmd_ready = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
    assign accept    = cmd_valid && cmd_ready;

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB4_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            // A new command can be taken from IDLE or straight out of RESP.
            if (accept) begin
                paddr     <= cmd_addr;
                pwrite    <= cmd_write;
                pwdata    <= cmd_wdata;
                pstrb     <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
                pprot     <= cmd_prot;
                psel      <= 1'b1;
                penable   <= 1'b0;
                rsp_valid <= 1'b0;
                state     <= S_SETUP;
            end else begin
                case (state)
                    S_SETUP: begin
                        penable <= 1'b1;
                        state   <= S_ACCESS;
`ifdef APB4_MASTER_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                    S_ACCESS: begin
                        if (pready) begin
                            rsp_rdata <= pwrite ? '0 : prdata;
                            rsp_err   <= pslverr;
                            rsp_valid <= 1'b1;
                            psel      <= 1'b0;
                            penable   <= 1'b0;
                            state     <= S_RESP;
`ifdef APB4_MASTER_TIMEOUT_EN
                        end else if (tmo_cnt == CNT_LAST) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            psel      <= 1'b0;
                            penable   <= 1'b0;
                            state     <= S_RESP;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
`endif
                        end
                    end
                    S_RESP: begin
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master: write, waited read, error with backpressure,
// back-to-back, ACCESS stall/timeout and asynchronous reset mid-transfer.
module tb_apb4_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    int n_checks = 0;
    int n_errors = 0;

    apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
    endtask

    initial begin
        int acc;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

        // Reset state
        repeat (2) cyc();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pstrb", pstrb, 0);
        rst_n = 1'b1;
        cyc();
        check("rst_cmd_ready", cmd_ready, 1);

        // Write, zero wait states
        send(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b010);
        pready = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        check("wr_setup_psel", psel, 1);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_paddr", paddr, 32'h4);
        check("wr_setup_pwrite", pwrite, 1);
        check("wr_setup_pprot", pprot, 3'b010);
        check("wr_setup_cmd_ready", cmd_ready, 0);
        cyc();
        check("wr_access_penable", penable, 1);
        check("wr_access_pwdata", pwdata, 32'hDEADBEEF);
        check("wr_access_pstrb", pstrb, 4'hF);
        cyc();
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_psel", psel, 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("wr_done_rsp_valid", rsp_valid, 0);
        check("wr_done_cmd_ready", cmd_ready, 1);
        check("wr_done_paddr_hold", paddr, 32'h4);

        // Read with three wait states
        send(1'b0, 32'h8, 32'hFFFFFFFF, 4'hF, 3'b000);
        pready = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        check("rd_setup_pstrb", pstrb, 0);
        check("rd_setup_paddr", paddr, 32'h8);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("rd_access_paddr", paddr, 32'h8);
            check("rd_access_sel_en", {psel, penable}, 2'b11);
            check("rd_access_rsp_valid", rsp_valid, 0);
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'h12345678;
            end
        end
        cyc();
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
        check("rd_rsp_err", rsp_err, 0);
        pready = 1'b0; prdata = '0; rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        // Slave error with response backpressure
        send(1'b1, 32'hC, 32'h55, 4'h3, 3'b000);
        pready = 1'b1; pslverr = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("err_rsp_valid", rsp_valid, 1);
            check("err_rsp_err", rsp_err, 1);
            check("err_psel", psel, 0);
            check("err_cmd_ready", cmd_ready, 0);
            cyc();
        end
        check("err_rsp_rdata", rsp_rdata, 0);
        pslverr = 1'b0; rsp_ready = 1'b1;
        cyc();
        check("err_done_rsp_valid", rsp_valid, 0);

        // Back-to-back: B is held during A's transfer and accepted from RESP
        send(1'b1, 32'h10, 32'h11112222, 4'hF, 3'b001);
        pready = 1'b1;
        cyc();
        send(1'b0, 32'h14, 32'h0, 4'hF, 3'b000);
        check("b2b_a_setup_paddr", paddr, 32'h10);
        check("b2b_a_cmd_ready", cmd_ready, 0);
        cyc();
        check("b2b_a_access_paddr", paddr, 32'h10);
        check("b2b_a_access_pwrite", pwrite, 1);
        prdata = 32'hA5A50001;
        cyc();
        check("b2b_a_rsp_valid", rsp_valid, 1);
        check("b2b_gap_psel", psel, 0);
        check("b2b_resp_cmd_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        check("b2b_b_setup_sel_en", {psel, penable}, 2'b10);
        check("b2b_b_paddr", paddr, 32'h14);
        check("b2b_b_pstrb", pstrb, 0);
        check("b2b_b_rsp_valid", rsp_valid, 0);
        cyc();
        check("b2b_b_access_penable", penable, 1);
        cyc();
        check("b2b_b_rsp_valid", rsp_valid, 1);
        check("b2b_b_rsp_rdata", rsp_rdata, 32'hA5A50001);
        cyc();
        rsp_ready = 1'b0; pready = 1'b0;

`ifdef APB4_MASTER_TIMEOUT_EN
        // Timeout: pready never rises
        prdata = 32'hBAD0BAD0;
        send(1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
        cyc();
        cmd_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (psel && penable) acc++;
        end
        check("tmo_access_cycles", acc, 16);
        cyc();
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_rdata", rsp_rdata, 0);
        check("tmo_psel", psel, 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        send(1'b0, 32'h24, 32'h0, 4'h0, 3'b000);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
`else
        // Without the watchdog ACCESS waits indefinitely
        send(1'b0, 32'h24, 32'h0, 4'h0, 3'b000);
        cyc();
        cmd_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (psel && penable) acc++;
        end
        check("stall_access_cycles", acc, 100);
        check("stall_rsp_valid", rsp_valid, 0);
`endif

        // Asynchronous reset in the middle of ACCESS wait states
        check("rst_mid_in_access", {psel, penable}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable", penable, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_paddr", paddr, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("rst_rel_cmd_ready", cmd_ready, 1);
        cyc();
        check("rst_rel_psel", psel, 0);
        check("rst_rel_rsp_valid", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
